servo_pwm_multi: RTL
====================

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter NCH, 2, number of servo channels (1..8).
REQ-002 Parameter PERIOD, 540000, clk cycles per PWM frame (20 ms at 27 MHz).
REQ-003 Parameter CW, 20, width of the frame counter and all position values.
REQ-004 Parameter MIN_POS, 27000, lowest legal pulse width in clk cycles.
REQ-005 Parameter MAX_POS, 54000, highest legal pulse width in clk cycles.
REQ-006 Parameter CENTER_POS, 40500, reset and centre pulse width.
REQ-007 Parameter STEP, 100, step-command increment and maximum slew per frame.
REQ-008 Port clk, input, 1, system clock (27 MHz).
REQ-009 Port rst_n, input, 1, reset (asynchronous, active-low).
REQ-010 Port cmd_valid, input, 1, command present.
REQ-011 Port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-012 Port cmd_ch, input, max(1,$clog2(NCH)), target channel.
REQ-013 Port cmd_op, input, 3, command code: 000 nop, 001 step down, 010 step up, 011 centre, 100 absolute set, others nop.
REQ-014 Port cmd_pos, input, CW, absolute target for op 100.
REQ-015 Port pwm, output, NCH, registered servo pulse per channel.
REQ-016 Port frame_start, output, 1, one-cycle pulse at frame counter 0.
REQ-017 Port at_target, output, NCH, bit i high when cur[i] equals tgt[i].

Function
REQ-018 The frame counter SHALL count 0..PERIOD-1 and then wrap to 0, every clk cycle.
REQ-019 Cycle cnt==PERIOD-1 is the update cycle: each cur[i] SHALL move toward tgt[i] by min(STEP, |tgt[i]-cur[i]|).
REQ-020 pwm[i] SHALL be registered, high while cnt < cur[i]; cur SHALL change only in the update cycle, giving glitch-free pulses.
REQ-021 frame_start SHALL be high for exactly the one cycle in which cnt==0.
REQ-022 cmd_ready SHALL be 0 in the update cycle and 1 in all other cycles out of reset.
REQ-023 An accepted command SHALL update tgt[cmd_ch] on the next edge; the affected pwm changes at the earliest after the following update cycle.
REQ-024 Op 001 SHALL set tgt to tgt-STEP; op 010 to tgt+STEP; op 011 to CENTER_POS; op 100 to cmd_pos.
REQ-025 Every target result SHALL be clamped to [MIN_POS, MAX_POS], computed at CW+1 bits so no wrap-around occurs.
REQ-026 A command with cmd_ch >= NCH SHALL be accepted and ignored.
REQ-027 at_target SHALL be registered, reflecting cur/tgt after each edge.

Reset
REQ-028 While rst_n is low: cnt=0, cur[i]=tgt[i]=CENTER_POS, pwm=0, frame_start=0, cmd_ready=0, at_target all 1.
REQ-029 Reset asserted mid-frame SHALL force pwm low immediately (asynchronously); the frame restarts at cnt=0 after release.

Configuration
REQ-030 With SERVO_SOFTSTART_EN defined, pwm[i] SHALL stay 0 until channel i receives its first accepted non-nop command, and then be enabled from the next frame start; reset re-disarms all channels.
REQ-031 Without SERVO_SOFTSTART_EN, all channels SHALL be enabled from the first frame after reset.

Verification
REQ-032 Reset release, no commands, macro off -> pwm[0] and pwm[1] high for 40500 of every 540000 cycles; frame_start pulses every 540000 cycles.
REQ-033 Op 100, ch1, cmd_pos=54000 -> cur[1] rises by 100 per frame; at_target[1] is 0 for 135 frames and 1 afterwards with a 54000-cycle pulse.
REQ-034 Op 100 with cmd_pos=60000, then 10000 -> tgt clamped to 54000, then 27000; op 001 at tgt 27000 -> tgt stays 27000.
REQ-035 cmd_valid held with op 010 across the update cycle -> cmd_ready=0 there, command accepted one cycle later, tgt=40600, exactly one step applied.
REQ-036 rst_n pulsed low at cnt=20000 while pwm high -> pwm low in the same cycle, cur reset to 40500, next pulse 40500 cycles long.
REQ-037 SERVO_SOFTSTART_EN defined -> pwm[0] stays 0 until op 011 is sent on ch0, then 40500-cycle pulses from the next frame; pwm[1] stays 0 throughout.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM with slew-limited, clamped position targets
// Optional feature macro: SERVO_SOFTSTART_EN (keep each pwm low until that channel's first real command)
module servo_pwm_multi #(
    parameter int NCH        = 2,
    parameter int PERIOD     = 540000,
    parameter int CW         = 20,
    parameter int MIN_POS    = 27000,
    parameter int MAX_POS    = 54000,
    parameter int CENTER_POS = 40500,
    parameter int STEP       = 100,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [2:0]      cmd_op,
    input  logic [CW-1:0]   cmd_pos,
    output logic [NCH-1:0]  pwm,
    output logic            frame_start,
    output logic [NCH-1:0]  at_target
);

    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CENTER_C = CW'(CENTER_POS);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_POS);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_POS);
    localparam logic [CW-1:0] STEP_C   = CW'(STEP);
    localparam logic [CW:0]   MIN_W    = (CW+1)'(MIN_POS);
    localparam logic [CW:0]   MAX_W    = (CW+1)'(MAX_POS);
    localparam logic [CW:0]   STEP_W   = (CW+1)'(STEP);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cur_q [NCH];
    logic [CW-1:0]  cur_d [NCH];
    logic [CW-1:0]  tgt_q [NCH];
    logic [CW-1:0]  tgt_d [NCH];
    logic [NCH-1:0] pwm_q, pwm_d;
    logic [NCH-1:0] at_target_q, at_target_d;
    logic [NCH-1:0] en;
    logic           update;
    logic           accept;

    // Targets are computed one bit wider so step up/down can never wrap before clamping.
    function automatic logic [CW-1:0] clamp(input logic [CW:0] v);
        if (v < MIN_W) return MIN_C;
        if (v > MAX_W) return MAX_C;
        return v[CW-1:0];
    endfunction

    // The last cycle of the frame is reserved for moving cur, so commands are held off there.
    assign update      = (cnt_q == LAST);
    assign cmd_ready   = rst_n & ~update;
    assign frame_start = rst_n & (cnt_q == '0);
    assign accept      = cmd_valid & cmd_ready;
    assign pwm         = pwm_q;
    assign at_target   = at_target_q;

    // Frame counter wraps after the update cycle.
    always_comb begin
        cnt_d = update ? '0 : cnt_q + CW'(1);
    end

    // Command decode: new target for the addressed channel; out-of-range channels match nothing.
    always_comb begin
        logic [CW:0] base;
        base = '0;
        for (int i = 0; i < NCH; i++) begin
            tgt_d[i] = tgt_q[i];
            if (accept && (cmd_ch == CHW'(i))) begin
                base = {1'b0, tgt_q[i]};
                case (cmd_op)
                    3'b001:  tgt_d[i] = clamp((base > STEP_W) ? base - STEP_W : '0);
                    3'b010:  tgt_d[i] = clamp(base + STEP_W);
                    3'b011:  tgt_d[i] = clamp({1'b0, CENTER_C});
                    3'b100:  tgt_d[i] = clamp({1'b0, cmd_pos});
                    default: tgt_d[i] = tgt_q[i];
                endcase
            end
        end
    end

    // Slew: once per frame cur moves toward tgt by at most STEP, landing exactly on tgt.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cur_d[i] = cur_q[i];
            if (update) begin
                if (tgt_q[i] > cur_q[i])
                    cur_d[i] = ((tgt_q[i] - cur_q[i]) > STEP_C) ? cur_q[i] + STEP_C : tgt_q[i];
                else if (tgt_q[i] < cur_q[i])
                    cur_d[i] = ((cur_q[i] - tgt_q[i]) > STEP_C) ? cur_q[i] - STEP_C : tgt_q[i];
            end
        end
    end

    // Pulse compare and target flags; cur only moves at the frame boundary so pulses never glitch.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i]       = en[i] & (cnt_q < cur_q[i]);
            at_target_d[i] = (cur_d[i] == tgt_d[i]);
        end
    end

`ifdef SERVO_SOFTSTART_EN
    logic [NCH-1:0] arm_q, arm_d;
    logic [NCH-1:0] en_q, en_d;

    // A channel arms on its first non-nop command and goes live at the next frame boundary.
    always_comb begin
        arm_d = arm_q;
        for (int i = 0; i < NCH; i++) begin
            if (accept && (cmd_ch == CHW'(i)) && (cmd_op inside {3'b001, 3'b010, 3'b011, 3'b100}))
                arm_d[i] = 1'b1;
        end
        en_d = update ? arm_q : en_q;
    end

    // Arm/enable state; reset disarms every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= '0;
            en_q  <= '0;
        end else begin
            arm_q <= arm_d;
            en_q  <= en_d;
        end
    end

    assign en = en_q;
`else
    assign en = '1;
`endif

    // State registers; reset drops pwm immediately and recentres every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pwm_q       <= '0;
            at_target_q <= '1;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= CENTER_C;
                tgt_q[i] <= CENTER_C;
            end
        end else begin
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            at_target_q <= at_target_d;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

endmodule
